// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, fetch buffer entry type and PC helpers for the fetch stage
package fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xword_t;

  localparam xword_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam xword_t PC_STEP          = 32'd4;

  typedef struct packed {
    xword_t pc;
    xword_t instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_aligned(input xword_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - ROM, redirect and decode-side signals of the fetch stage
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  xword_t rom_addr;
  xword_t rom_data;
  logic   redirect_valid;
  xword_t redirect_pc;
  logic   out_valid;
  logic   out_ready;
  xword_t out_instr;
  xword_t out_pc;
  logic   fetch_fault;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, fetch_fault,
    input  rom_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, fetch_fault,
    output rom_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - synchronous fetch buffer holding {pc, instr} pairs; flush beats push
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop alongside a flush is still a completed handshake; the flush just discards the rest.
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & ~flush_i & (~full_o | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head_o is masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, redirect handling and fault flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter xword_t RESET_PC = RESET_PC_DEFAULT,
  parameter int     DEPTH    = 2
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);

  xword_t       pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t wr_entry, head_entry;

  assign pop  = ~fifo_empty & bus.out_ready;
  assign push = ~bus.redirect_valid & ~fault_q & (~fifo_full | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = bus.rom_data;

  // A redirect replaces any sequential advance; a misaligned target parks the PC and halts fetch.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ~32'h3;
      fault_d = ~is_aligned(bus.redirect_pc);
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wr_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_entry)
  );

  assign bus.rom_addr    = pc_q;
  assign bus.out_valid   = ~fifo_empty;
  assign bus.out_pc      = head_entry.pc;
  assign bus.out_instr   = head_entry.instr;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00a5_4533;
      32'h0000_0004: return 32'h0052_c2b3;
      32'h0000_001c: return 32'h0000_0063;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = target;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] got;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    tick();
    tick();
    got = {bus.out_valid, bus.fetch_fault, bus.out_pc, bus.out_instr, bus.rom_addr};
    tests_run++;
    if (got !== 98'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0", got);
    end
    rst_n = 1'b1;
    tests_run++;
    if (bus.rom_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rom_addr: got %h want 00000000", bus.rom_addr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h0, 32'h00a54533}) begin
      tests_failed++;
      $display("FAIL first_fetch: got v=%b pc=%h ins=%h want v=1 pc=00000000 ins=00a54533",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h4, 32'h0052c2b3}) begin
      tests_failed++;
      $display("FAIL second_fetch: got v=%b pc=%h ins=%h want v=1 pc=00000004 ins=0052c2b3",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.rom_addr} !== {1'b1, 32'h0, 32'h8}) begin
      tests_failed++;
      $display("FAIL stall_full: got v=%b pc=%h rom=%h want v=1 pc=00000000 rom=00000008",
               bus.out_valid, bus.out_pc, bus.rom_addr);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'(4 * k), rom_word(32'(4 * k))}) begin
        tests_failed++;
        $display("FAIL drain_seq[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k,
                 bus.out_valid, bus.out_pc, bus.out_instr, 32'(4 * k), rom_word(32'(4 * k)));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect(32'h1c);
    tests_run++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 32'h1c}) begin
      tests_failed++;
      $display("FAIL redirect_flush: got v=%b rom=%h want v=0 rom=0000001c",
               bus.out_valid, bus.rom_addr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr} !==
        {1'b1, 32'h1c, 32'h00000063, 32'h20}) begin
      tests_failed++;
      $display("FAIL redirect_target: got v=%b pc=%h ins=%h rom=%h want v=1 pc=0000001c ins=00000063 rom=00000020",
               bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr);
    end
  endtask

  task automatic test_misaligned();
    redirect(32'h1e);
    tests_run++;
    if ({bus.fetch_fault, bus.out_valid, bus.rom_addr} !== {1'b1, 1'b0, 32'h1c}) begin
      tests_failed++;
      $display("FAIL fault_set: got f=%b v=%b rom=%h want f=1 v=0 rom=0000001c",
               bus.fetch_fault, bus.out_valid, bus.rom_addr);
    end
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if ({bus.fetch_fault, bus.out_valid, bus.rom_addr} !== {1'b1, 1'b0, 32'h1c}) begin
      tests_failed++;
      $display("FAIL fault_hold: got f=%b v=%b rom=%h want f=1 v=0 rom=0000001c",
               bus.fetch_fault, bus.out_valid, bus.rom_addr);
    end
    redirect(32'h4);
    tests_run++;
    if ({bus.fetch_fault, bus.out_valid, bus.rom_addr} !== {1'b0, 1'b0, 32'h4}) begin
      tests_failed++;
      $display("FAIL fault_clear: got f=%b v=%b rom=%h want f=0 v=0 rom=00000004",
               bus.fetch_fault, bus.out_valid, bus.rom_addr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h4, 32'h0052c2b3}) begin
      tests_failed++;
      $display("FAIL fault_resume: got v=%b pc=%h ins=%h want v=1 pc=00000004 ins=0052c2b3",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    tests_run++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("FAIL wrap_redirect: got v=%b rom=%h want v=0 rom=fffffffc",
               bus.out_valid, bus.rom_addr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.fetch_fault, bus.out_pc, bus.out_instr, bus.rom_addr} !==
        {1'b1, 1'b0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap_last: got v=%b f=%b pc=%h ins=%h rom=%h want v=1 f=0 pc=fffffffc ins=%h rom=00000000",
               bus.out_valid, bus.fetch_fault, bus.out_pc, bus.out_instr, bus.rom_addr,
               rom_word(32'hFFFF_FFFC));
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h0, 32'h00a54533}) begin
      tests_failed++;
      $display("FAIL wrap_zero: got v=%b pc=%h ins=%h want v=1 pc=00000000 ins=00a54533",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    redirect(32'h1c);
    tests_run++;
    if ({bus.out_valid, bus.rom_addr} !== {1'b0, 32'h1c}) begin
      tests_failed++;
      $display("FAIL b2b_flush: got v=%b rom=%h want v=0 rom=0000001c",
               bus.out_valid, bus.rom_addr);
    end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h1c, 32'h00000063}) begin
      tests_failed++;
      $display("FAIL b2b_target: got v=%b pc=%h ins=%h want v=1 pc=0000001c ins=00000063",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_async_reset();
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_stream: got v=%b want v=1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.rom_addr, bus.out_pc, bus.out_instr} !== {1'b0, 96'h0}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b rom=%h pc=%h ins=%h want all 0",
               bus.out_valid, bus.rom_addr, bus.out_pc, bus.out_instr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
